// File: rtl/gb_cpu_microseq.sv
// M-cycle micro-sequencer: plays a decoder-supplied schedule of control words and
// handles condition early exit, 0xCB chaining, interrupt dispatch, HALT and stall.
module gb_cpu_microseq #(
    parameter int unsigned CTRL_W = 32,
    parameter int unsigned MAX_MCYC = 6,
    parameter logic [CTRL_W-1:0] FETCH_CTRL = 'h1,
    parameter logic [CTRL_W-1:0] HALT_CTRL = '0,
    parameter logic [CTRL_W-1:0] NOP_CTRL = '0,
    localparam int unsigned SW = (MAX_MCYC > 1) ? $clog2(MAX_MCYC) : 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         stall,
    input  logic [MAX_MCYC*CTRL_W-1:0]   sched_ctrl,
    input  logic [SW-1:0]                sched_len,
    input  logic                         sched_prefix_next,
    input  logic                         sched_halt,
    input  logic                         cond_fail,
    input  logic                         int_pending,
    input  logic                         ime,
    output logic [CTRL_W-1:0]            ctrl_next,
    output logic [SW-1:0]                step_o,
    output logic                         last_step_o,
    output logic                         cb_prefix_o,
    output logic                         isr_cmd,
    output logic                         halted_o
);

    typedef enum logic [1:0] {S_FETCH, S_EXEC, S_HALT} state_t;

    localparam logic [SW-1:0] LEN_MAX = SW'(MAX_MCYC - 1);

    state_t          state_q, state_d;
    logic [SW-1:0]   step_q, step_d;
    logic [SW-1:0]   len_q, len_d;
    logic            cb_q, cb_d;
    logic            isr_q, isr_d;

    logic [SW-1:0]   raw_len;
    logic [SW-1:0]   eff_len;
    logic [CTRL_W-1:0] word;
    logic            last;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
            step_q  <= '0;
            len_q   <= '0;
            cb_q    <= 1'b0;
            isr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            len_q   <= len_d;
            cb_q    <= cb_d;
            isr_q   <= isr_d;
        end
    end

    // Length comes straight from the decoder on step 0, from the latched copy afterwards.
    always_comb begin
        raw_len = (step_q == '0) ? sched_len : len_q;
        eff_len = (raw_len > LEN_MAX) ? LEN_MAX : raw_len;
        last    = (state_q == S_EXEC) && (step_q == eff_len);
        word    = '0;
        for (int unsigned k = 0; k < MAX_MCYC; k++) begin
            if (step_q == SW'(k)) word = sched_ctrl[k*CTRL_W +: CTRL_W];
        end
    end

    always_comb begin
        if (stall) begin
            ctrl_next = NOP_CTRL;
        end else begin
            case (state_q)
                S_FETCH: ctrl_next = FETCH_CTRL;
                S_EXEC:  ctrl_next = word;
                S_HALT:  ctrl_next = HALT_CTRL;
                default: ctrl_next = FETCH_CTRL;
            endcase
        end
        step_o      = step_q;
        last_step_o = last;
        cb_prefix_o = cb_q;
        isr_cmd     = isr_q;
        halted_o    = (state_q == S_HALT);
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        len_d   = len_q;
        cb_d    = cb_q;
        isr_d   = isr_q;
        if (!stall) begin
            case (state_q)
                S_FETCH: begin
                    state_d = S_EXEC;
                    step_d  = '0;
                end
                S_EXEC: begin
                    if (step_q == '0) len_d = eff_len;
                    // A failed condition on the final word is moot: the op ends anyway.
                    if (last) begin
                        step_d = '0;
                        cb_d   = sched_prefix_next;
                        isr_d  = ~sched_prefix_next & ime & int_pending;
                        if (sched_halt && !int_pending) begin
                            state_d = S_HALT;
                            isr_d   = 1'b0;
                        end
                    end else if (cond_fail) begin
                        state_d = S_FETCH;
                        step_d  = '0;
                        cb_d    = 1'b0;
                        isr_d   = 1'b0;
                    end else begin
                        step_d = step_q + 1'b1;
                    end
                end
                S_HALT: begin
                    if (int_pending) begin
                        step_d = '0;
                        if (ime) begin
                            state_d = S_EXEC;
                            isr_d   = 1'b1;
                        end else begin
                            state_d = S_FETCH;
                            isr_d   = 1'b0;
                        end
                    end
                end
                default: begin
                    state_d = S_FETCH;
                    step_d  = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gb_cpu_microseq.sv
module tb_gb_cpu_microseq;

  localparam int unsigned CTRL_W = 32;
  localparam int unsigned MAX_MCYC = 6;
  localparam int unsigned SW = 3;

  logic                       clk;
  logic                       reset;
  logic                       stall;
  logic [MAX_MCYC*CTRL_W-1:0] sched_ctrl;
  logic [SW-1:0]              sched_len;
  logic                       sched_prefix_next;
  logic                       sched_halt;
  logic                       cond_fail;
  logic                       int_pending;
  logic                       ime;
  logic [CTRL_W-1:0]          ctrl_next;
  logic [SW-1:0]              step_o;
  logic                       last_step_o;
  logic                       cb_prefix_o;
  logic                       isr_cmd;
  logic                       halted_o;

  int tests = 0;
  int fails = 0;

  gb_cpu_microseq #(
    .CTRL_W(CTRL_W),
    .MAX_MCYC(MAX_MCYC),
    .FETCH_CTRL(32'h0000_0001),
    .HALT_CTRL(32'h0000_0000),
    .NOP_CTRL(32'h0000_0000)
  ) dut (
    .clk(clk),
    .reset(reset),
    .stall(stall),
    .sched_ctrl(sched_ctrl),
    .sched_len(sched_len),
    .sched_prefix_next(sched_prefix_next),
    .sched_halt(sched_halt),
    .cond_fail(cond_fail),
    .int_pending(int_pending),
    .ime(ime),
    .ctrl_next(ctrl_next),
    .step_o(step_o),
    .last_step_o(last_step_o),
    .cb_prefix_o(cb_prefix_o),
    .isr_cmd(isr_cmd),
    .halted_o(halted_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_words(input logic [31:0] base);
    for (int unsigned k = 0; k < MAX_MCYC; k++) sched_ctrl[k*CTRL_W +: CTRL_W] = base + 32'(k);
  endtask

  initial begin
    reset = 1'b0;
    stall = 1'b0;
    sched_ctrl = '0;
    sched_len = 3'd0;
    sched_prefix_next = 1'b0;
    sched_halt = 1'b0;
    cond_fail = 1'b0;
    int_pending = 1'b0;
    ime = 1'b0;
    set_words(32'hA0);
    #2;
    check("rst_ctrl", ctrl_next, 32'h1);
    check("rst_step", step_o, 3'd0);
    check("rst_last", last_step_o, 1'b0);
    check("rst_cb", cb_prefix_o, 1'b0);
    check("rst_isr", isr_cmd, 1'b0);
    check("rst_halt", halted_o, 1'b0);

    // single-word ops
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("t1_fetch", ctrl_next, 32'h1);
    for (int unsigned i = 0; i < 3; i++) begin
      tick();
      check("t1_ctrl", ctrl_next, 32'hA0);
      check("t1_step", step_o, 3'd0);
      check("t1_last", last_step_o, 1'b1);
    end

    // four-word op
    sched_len = 3'd3;
    #1;
    check("t2_w0", ctrl_next, 32'hA0);
    check("t2_l0", last_step_o, 1'b0);
    tick();
    check("t2_w1", ctrl_next, 32'hA1);
    check("t2_s1", step_o, 3'd1);
    check("t2_l1", last_step_o, 1'b0);
    tick();
    check("t2_w2", ctrl_next, 32'hA2);
    check("t2_s2", step_o, 3'd2);
    check("t2_l2", last_step_o, 1'b0);
    tick();
    check("t2_w3", ctrl_next, 32'hA3);
    check("t2_s3", step_o, 3'd3);
    check("t2_l3", last_step_o, 1'b1);
    tick();
    check("t2_wrap", ctrl_next, 32'hA0);
    check("t2_swrap", step_o, 3'd0);

    // condition failure mid-op
    set_words(32'hB0);
    sched_len = 3'd4;
    #1;
    check("t3_w0", ctrl_next, 32'hB0);
    tick();
    cond_fail = 1'b1;
    #1;
    check("t3_w1", ctrl_next, 32'hB1);
    check("t3_s1", step_o, 3'd1);
    tick();
    cond_fail = 1'b0;
    #1;
    check("t3_fetch", ctrl_next, 32'h1);
    check("t3_step", step_o, 3'd0);
    check("t3_cb", cb_prefix_o, 1'b0);
    check("t3_isr", isr_cmd, 1'b0);
    tick();
    check("t3_w0b", ctrl_next, 32'hB0);

    // cond_fail on a last step is ignored
    sched_len = 3'd0;
    cond_fail = 1'b1;
    #1;
    check("t3_lastc", last_step_o, 1'b1);
    tick();
    cond_fail = 1'b0;
    #1;
    check("t3_noexit", ctrl_next, 32'hB0);
    check("t3_noexit_l", last_step_o, 1'b1);

    // 0xCB prefix blocks dispatch until the suffix completes
    sched_prefix_next = 1'b1;
    ime = 1'b1;
    int_pending = 1'b1;
    tick();
    check("t4_cb1", cb_prefix_o, 1'b1);
    check("t4_isr0", isr_cmd, 1'b0);
    sched_prefix_next = 1'b0;
    sched_len = 3'd1;
    tick();
    check("t4_sfx_s1", step_o, 3'd1);
    check("t4_sfx_cb", cb_prefix_o, 1'b1);
    check("t4_sfx_last", last_step_o, 1'b1);
    tick();
    check("t4_cb0", cb_prefix_o, 1'b0);
    check("t4_isr1", isr_cmd, 1'b1);
    ime = 1'b0;
    int_pending = 1'b0;
    sched_len = 3'd0;
    tick();
    check("t4_isr_clr", isr_cmd, 1'b0);

    // HALT, woken with ime=1
    sched_halt = 1'b1;
    tick();
    sched_halt = 1'b0;
    #1;
    for (int unsigned i = 0; i < 5; i++) begin
      check("t5_halted", halted_o, 1'b1);
      check("t5_hctrl", ctrl_next, 32'h0);
      tick();
    end
    int_pending = 1'b1;
    ime = 1'b1;
    tick();
    check("t5_wake_h", halted_o, 1'b0);
    check("t5_wake_isr", isr_cmd, 1'b1);
    check("t5_wake_ctrl", ctrl_next, 32'hB0);
    check("t5_wake_step", step_o, 3'd0);
    // HALT again, woken with ime=0
    int_pending = 1'b0;
    ime = 1'b0;
    sched_halt = 1'b1;
    tick();
    sched_halt = 1'b0;
    #1;
    check("t5_halt2", halted_o, 1'b1);
    check("t5_isr_h2", isr_cmd, 1'b0);
    int_pending = 1'b1;
    tick();
    int_pending = 1'b0;
    #1;
    check("t5_fetch", ctrl_next, 32'h1);
    check("t5_fetch_isr", isr_cmd, 1'b0);
    check("t5_fetch_h", halted_o, 1'b0);
    tick();

    // stall at step 2; inputs that would otherwise act are ignored
    set_words(32'hC0);
    sched_len = 3'd3;
    #1;
    check("t6_w0", ctrl_next, 32'hC0);
    tick();
    tick();
    check("t6_w2", ctrl_next, 32'hC2);
    stall = 1'b1;
    cond_fail = 1'b1;
    #1;
    check("t6_nop1", ctrl_next, 32'h0);
    check("t6_s1", step_o, 3'd2);
    tick();
    check("t6_nop2", ctrl_next, 32'h0);
    check("t6_s2", step_o, 3'd2);
    tick();
    stall = 1'b0;
    cond_fail = 1'b0;
    #1;
    check("t6_replay", ctrl_next, 32'hC2);
    check("t6_rstep", step_o, 3'd2);
    tick();
    check("t6_w3", ctrl_next, 32'hC3);
    check("t6_l3", last_step_o, 1'b1);
    tick();

    // out-of-range length clamps to MAX_MCYC-1
    set_words(32'hD0);
    sched_len = 3'd7;
    #1;
    check("t7_l0", last_step_o, 1'b0);
    for (int unsigned i = 0; i < 4; i++) tick();
    check("t7_s4", step_o, 3'd4);
    check("t7_l4", last_step_o, 1'b0);
    tick();
    check("t7_w5", ctrl_next, 32'hD5);
    check("t7_l5", last_step_o, 1'b1);
    tick();
    check("t7_wrap", step_o, 3'd0);

    // asynchronous reset mid-op
    sched_len = 3'd0;
    sched_prefix_next = 1'b1;
    tick();
    sched_prefix_next = 1'b0;
    sched_len = 3'd3;
    tick();
    check("t8_pre_cb", cb_prefix_o, 1'b1);
    check("t8_pre_s", step_o, 3'd1);
    reset = 1'b0;
    #1;
    check("t8_ctrl", ctrl_next, 32'h1);
    check("t8_step", step_o, 3'd0);
    check("t8_cb", cb_prefix_o, 1'b0);
    check("t8_last", last_step_o, 1'b0);
    #1;
    reset = 1'b1;
    #1;
    check("t8_fetch", ctrl_next, 32'h1);
    tick();
    check("t8_exec", ctrl_next, 32'hD0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/gb_cpu_microseq.md
Name: gb_cpu_microseq

Overview:
Parametrised M-cycle micro-sequencer for the gb CPU. It is the successor of the fixed CISC scheduler.
- Plays a decoder-supplied schedule of control words, one word per M-cycle.
- Handles condition-check early exit, 0xCB prefix chaining, interrupt dispatch, HALT wait and bus stall.
- Sits between the decoder/schedule ROM and the datapath; `ctrl_next` drives the datapath each M-cycle.

Parameters:
- CTRL_W, 32, width of one control word.
- MAX_MCYC, 6, maximum words per instruction, including the final fetch-overlapped word.
- FETCH_CTRL, 32'h0000_0001, standalone opcode-fetch word (IR<-[PC], PC++).
- HALT_CTRL, 32'h0000_0000, word emitted while halted (no PC increment).
- NOP_CTRL, 32'h0000_0000, word emitted during stall (all write enables 0).
- SW (localparam), $clog2(MAX_MCYC), step and length width.

Ports:
- clk  in  1  M-cycle clock
- reset  in  1  asynchronous, active-low reset
- stall  in  1  hold the sequencer this cycle (bus wait)
- sched_ctrl  in  MAX_MCYC*CTRL_W  flattened words; word k = bits [k*CTRL_W +: CTRL_W]
- sched_len  in  SW  index of the last word of the current op (0..MAX_MCYC-1)
- sched_prefix_next  in  1  current op is the 0xCB prefix
- sched_halt  in  1  current op is HALT
- cond_fail  in  1  condition check in this cycle's word failed
- int_pending  in  1  (IE & IF) != 0
- ime  in  1  interrupt master enable
- ctrl_next  out  CTRL_W  control word for this M-cycle
- step_o  out  SW  current step index
- last_step_o  out  1  current word is the op's last
- cb_prefix_o  out  1  decoder must use the CB table
- isr_cmd  out  1  decoder must supply the ISR schedule
- halted_o  out  1  in HALT state

Behaviour:
- States: FETCH, EXEC, HALT. Registers: state, step, len_q, cb_prefix_o, isr_cmd.
- Reset (asynchronous, reset=0): state=FETCH, step=0, len_q=0, cb_prefix_o=0, isr_cmd=0. Consequently halted_o=0 and ctrl_next=FETCH_CTRL.
- Combinational outputs, zero latency:
  - stall=1: ctrl_next=NOP_CTRL.
  - FETCH: ctrl_next=FETCH_CTRL.
  - HALT: ctrl_next=HALT_CTRL.
  - EXEC: ctrl_next=word[step].
- last_step_o = (state==EXEC) && (step==eff_len), where eff_len = min(step==0 ? sched_len : len_q, MAX_MCYC-1).
- len_q captures eff_len at step 0.
- Word[eff_len] carries the next-opcode fetch; this is the decoder's responsibility.
- stall=1: all registers hold; cond_fail and int_pending are ignored that cycle. The held word replays when stall drops.
- Transitions (stall=0):
  - FETCH -> EXEC, step=0.
  - EXEC with cond_fail=1 and not last -> FETCH, step=0, cb_prefix_o=0, isr_cmd=0.
  - EXEC with cond_fail=1 on the last step: cond_fail is ignored.
  - EXEC, not last -> step+1.
  - EXEC, last -> EXEC, step=0, and:
    - cb_prefix_o <= sched_prefix_next.
    - isr_cmd <= ~sched_prefix_next & ime & int_pending.
    - If sched_halt & ~int_pending: state=HALT instead, isr_cmd=0.
    - Prefix has priority over dispatch: interrupts are never taken between 0xCB and its suffix.
  - HALT, int_pending=0 -> stay.
  - HALT, int_pending=1 and ime=1 -> EXEC, step=0, isr_cmd=1.
  - HALT, int_pending=1 and ime=0 -> FETCH, isr_cmd=0.
- An ISR op is an ordinary schedule. At its last step, isr_cmd is recomputed by the same rule; ime is normally 0 then, so it clears.
- sched_len=0: single-word op; every cycle is a last step.
- Inputs sched_len >= MAX_MCYC are clamped to MAX_MCYC-1.
- Reset asserted mid-op aborts immediately. The first cycle after release is FETCH.

Test Plan:
- Reset release with sched_len=0, stall=0 -> cycle0 ctrl_next=FETCH_CTRL; every later cycle emits word[0], step_o=0, last_step_o=1.
- sched_len=3, words 0xA0..0xA3 -> ctrl_next sequence A0,A1,A2,A3,A0 with step_o 0,1,2,3,0; last_step_o high only on A3.
- sched_len=4, cond_fail=1 at step 1 -> next cycle FETCH_CTRL with step_o=0, then word[0]; cb_prefix_o=0 and isr_cmd=0 throughout.
- Prefix op: sched_prefix_next=1 with ime=1 and int_pending=1 at its last step -> cb_prefix_o=1, isr_cmd=0. At the suffix's last step (prefix_next=0) -> cb_prefix_o=0, isr_cmd=1.
- HALT op with int_pending=0 -> halted_o=1, HALT_CTRL for 5 cycles. Raise int_pending with ime=1 -> next cycle EXEC step 0, isr_cmd=1. Repeat with ime=0 -> FETCH_CTRL, isr_cmd=0.
- stall=1 for 2 cycles at step 2 of a 4-word op -> NOP_CTRL twice with step_o held at 2, then word[2] replays. Also pulse reset=0 mid-op -> outputs return immediately to reset values, with no clock edge needed.
